eth_10g_link_fault_sequencer: RTL and testbench

//  Controls the MAC TX reconciliation sublayer from the RX link-fault status stream (802.3 cl.46).

---
 rtl/eth_10g_lf_pkg.sv | 30 +++
 rtl/eth_10g_lf_debounce.sv | 48 ++++
 rtl/eth_10g_link_fault_sequencer.sv | 131 +++++++++++++
 tb/tb_eth_10g_link_fault_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/eth_10g_lf_pkg.sv
// Shared types for the 10G link-fault sequencer: FSM states, RX status codes
// and the state-to-event encoding.
package eth_10g_lf_pkg;

  typedef enum logic [1:0] {
    LINK_OK = 2'b00,
    LOCAL   = 2'b01,
    REMOTE  = 2'b10,
    HOLD    = 2'b11
  } lf_state_t;

  localparam logic [1:0] LF_NONE   = 2'b00;
  localparam logic [1:0] LF_LOCAL  = 2'b01;
  localparam logic [1:0] LF_REMOTE = 2'b10;
  localparam logic [1:0] LF_RSVD   = 2'b11;

  function automatic logic [1:0] state_code(input lf_state_t s);
    logic [1:0] code;
    code = 2'b11;
    case (s)
      LINK_OK: code = 2'b00;
      LOCAL:   code = 2'b01;
      REMOTE:  code = 2'b10;
      HOLD:    code = 2'b11;
      default: code = 2'b11;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/eth_10g_lf_debounce.sv
// Accepts a link-fault status once it has been seen DEBOUNCE_CYCLES times in a row
// on valid cycles; reserved codes and idle cycles neither extend nor break a run.
module eth_10g_lf_debounce
  import eth_10g_lf_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_data,
  input  logic       in_valid,
  output logic [1:0] acc,
  output logic       acc_valid
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  logic [1:0]    cand_q, cand_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    if (in_valid && (in_data != LF_RSVD)) begin
      if (in_data == cand_q) begin
        if (dcnt_q != DMAX) dcnt_d = dcnt_q + DW'(1);
      end else begin
        cand_d = in_data;
        dcnt_d = DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= LF_NONE;
      dcnt_q <= '0;
    end else begin
      cand_q <= cand_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign acc       = cand_q;
  assign acc_valid = (dcnt_q == DMAX);

endmodule

// File: rtl/eth_10g_link_fault_sequencer.sv
// Link-fault FSM driving the TX reconciliation controls, with a hold-off timer,
// a single-entry status-change event slot and a saturating fault counter.
module eth_10g_link_fault_sequencer
  import eth_10g_lf_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 128,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       in_data,
  input  logic             in_valid,
  output logic [1:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             evt_overflow,
  output logic             tx_send_rf,
  output logic             tx_send_idle,
  output logic             link_up,
  output logic [CNT_W-1:0] fault_count,
  input  logic             clr_count
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  logic [1:0] acc;
  logic       acc_valid;

  eth_10g_lf_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk       (clk),
    .rst       (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  lf_state_t        state_q, state_d;
  logic [HW-1:0]    hold_tmr_q, hold_tmr_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_data_q, out_data_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic             state_chg;

  always_comb begin
    state_d    = state_q;
    hold_tmr_d = hold_tmr_q;
    case (state_q)
      LINK_OK: begin
        if (acc_valid && acc == LF_LOCAL)       state_d = LOCAL;
        else if (acc_valid && acc == LF_REMOTE) state_d = REMOTE;
      end
      LOCAL: begin
        if (acc_valid && acc == LF_REMOTE) state_d = REMOTE;
        else if (acc_valid && acc == LF_NONE) begin
          state_d    = HOLD;
          hold_tmr_d = HOLD_INIT;
        end
      end
      REMOTE: begin
        if (acc_valid && acc == LF_LOCAL) state_d = LOCAL;
        else if (acc_valid && acc == LF_NONE) begin
          state_d    = HOLD;
          hold_tmr_d = HOLD_INIT;
        end
      end
      HOLD: begin
        // Timer only runs on accepted no-fault; a fault beats expiry.
        if (acc_valid && acc == LF_LOCAL)       state_d = LOCAL;
        else if (acc_valid && acc == LF_REMOTE) state_d = REMOTE;
        else if (acc_valid && acc == LF_NONE) begin
          if (hold_tmr_q == '0) state_d = LINK_OK;
          else                  hold_tmr_d = hold_tmr_q - HW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    evt_ovf_d   = evt_ovf_q;
    fault_cnt_d = fault_cnt_q;
    if (state_chg) begin
      out_valid_d = 1'b1;
      out_data_d  = state_code(state_d);
      if (out_valid_q && !out_ready) evt_ovf_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (state_chg && (state_d == LOCAL || state_d == REMOTE) && (fault_cnt_q != '1))
      fault_cnt_d = fault_cnt_q + CNT_W'(1);
    if (clr_count) begin
      fault_cnt_d = '0;
      evt_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      hold_tmr_q  <= HOLD_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= 2'b11;
      evt_ovf_q   <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_tmr_q  <= hold_tmr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      evt_ovf_q   <= evt_ovf_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign evt_overflow = evt_ovf_q;
  assign fault_count  = fault_cnt_q;
  assign tx_send_rf   = (state_q == LOCAL);
  assign tx_send_idle = (state_q == REMOTE) || (state_q == HOLD);
  assign link_up      = (state_q == LINK_OK);

endmodule

// File: tb/tb_eth_10g_link_fault_sequencer.sv
// Directed bench for the link-fault sequencer: a vector table of
// {inputs, cycles, expected outputs} plus hand-written latency and reset sequences.
module tb_eth_10g_link_fault_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  in_data = 2'b00;
  logic        in_valid = 1'b0;
  logic [1:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        evt_overflow;
  logic        tx_send_rf;
  logic        tx_send_idle;
  logic        link_up;
  logic [15:0] fault_count;
  logic        clr_count = 1'b0;

  eth_10g_link_fault_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (128),
    .CNT_W          (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .evt_overflow (evt_overflow),
    .tx_send_rf   (tx_send_rf),
    .tx_send_idle (tx_send_idle),
    .link_up      (link_up),
    .fault_count  (fault_count),
    .clr_count    (clr_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ev_cnt = 0;

  // Counts events actually handed to the consumer.
  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) ev_cnt <= ev_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] din;
    logic       vld;
    logic       rdy;
    logic       clr;
    int         ncyc;
    logic       link;
    logic       rf;
    logic       idle;
    logic       ov;
    logic [1:0] od;
    logic       ovf;
    int         cnt;
    int         nev;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  initial begin
    int cyc;
    int base;

    //              din  vld rdy clr ncyc link rf idle ov  od   ovf cnt nev
    vt[0]  = '{2'b01, 1, 1, 0,   3,  1, 0, 0, 0, 2'b00, 0, 0, 0}; // short 01 run
    vt[1]  = '{2'b00, 1, 1, 0,   1,  1, 0, 0, 0, 2'b00, 0, 0, 0};
    vt[2]  = '{2'b00, 1, 1, 0,   4,  1, 0, 0, 0, 2'b00, 0, 0, 0};
    vt[3]  = '{2'b01, 1, 1, 0,   4,  1, 0, 0, 0, 2'b00, 0, 0, 0}; // accepted, not yet acted on
    vt[4]  = '{2'b01, 1, 1, 0,   1,  0, 1, 0, 1, 2'b01, 0, 1, 0}; // LOCAL
    vt[5]  = '{2'b01, 1, 1, 0,   1,  0, 1, 0, 0, 2'b01, 0, 1, 1};
    vt[6]  = '{2'b10, 1, 1, 0,   5,  0, 0, 1, 1, 2'b10, 0, 2, 0}; // REMOTE
    vt[7]  = '{2'b00, 1, 1, 0,   5,  0, 0, 1, 1, 2'b11, 0, 2, 1}; // HOLD
    vt[8]  = '{2'b00, 1, 1, 0, 127,  0, 0, 1, 0, 2'b11, 0, 2, 1};
    vt[9]  = '{2'b00, 1, 1, 0,   1,  1, 0, 0, 1, 2'b00, 0, 2, 0}; // LINK_OK after 128
    vt[10] = '{2'b00, 1, 1, 0,   1,  1, 0, 0, 0, 2'b00, 0, 2, 1};
    vt[11] = '{2'b01, 1, 1, 0,   5,  0, 1, 0, 1, 2'b01, 0, 3, 0};
    vt[12] = '{2'b00, 1, 1, 0,   5,  0, 0, 1, 1, 2'b11, 0, 3, 1};
    vt[13] = '{2'b00, 1, 1, 0, 122,  0, 0, 1, 0, 2'b11, 0, 3, 1}; // hold_tmr = 5
    vt[14] = '{2'b10, 1, 1, 0,   4,  0, 0, 1, 0, 2'b11, 0, 3, 0};
    vt[15] = '{2'b10, 1, 1, 0,   1,  0, 0, 1, 1, 2'b10, 0, 4, 0}; // REMOTE, not LINK_OK
    vt[16] = '{2'b00, 1, 0, 0,   5,  0, 0, 1, 1, 2'b11, 1, 4, 0}; // overwrite pending
    vt[17] = '{2'b01, 1, 0, 0,   5,  0, 1, 0, 1, 2'b01, 1, 5, 0};
    vt[18] = '{2'b01, 1, 1, 1,   1,  0, 1, 0, 0, 2'b01, 0, 0, 1}; // clear
    vt[19] = '{2'b10, 1, 1, 0,   5,  0, 0, 1, 1, 2'b10, 0, 1, 0};
    vt[20] = '{2'b01, 1, 1, 0,   1,  0, 0, 1, 0, 2'b10, 0, 1, 1}; // 01 run with 11 and idle gaps
    vt[21] = '{2'b11, 1, 1, 0,   1,  0, 0, 1, 0, 2'b10, 0, 1, 0};
    vt[22] = '{2'b01, 1, 1, 0,   1,  0, 0, 1, 0, 2'b10, 0, 1, 0};
    vt[23] = '{2'b10, 0, 1, 0,   3,  0, 0, 1, 0, 2'b10, 0, 1, 0};
    vt[24] = '{2'b11, 1, 1, 0,   2,  0, 0, 1, 0, 2'b10, 0, 1, 0};
    vt[25] = '{2'b01, 1, 1, 0,   2,  0, 0, 1, 0, 2'b10, 0, 1, 0};
    vt[26] = '{2'b11, 1, 1, 0,   1,  0, 1, 0, 1, 2'b01, 0, 2, 0};
    vt[27] = '{2'b00, 1, 1, 0,   5,  0, 0, 1, 1, 2'b11, 0, 2, 1}; // back in HOLD

    repeat (3) @(negedge clk);
    check("rst.link_up",   int'(link_up), 0);
    check("rst.send_idle", int'(tx_send_idle), 1);
    check("rst.send_rf",   int'(tx_send_rf), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_data",  int'(out_data), 3);
    check("rst.overflow",  int'(evt_overflow), 0);
    check("rst.count",     int'(fault_count), 0);

    reset    = 1'b0;
    in_data  = 2'b00;
    in_valid = 1'b1;
    cyc = 0;
    while (!link_up && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("t1.latency",   cyc, 132);
    check("t1.out_valid", int'(out_valid), 1);
    check("t1.out_data",  int'(out_data), 0);
    base = ev_cnt;
    @(negedge clk);
    check("t1.slot_empty", int'(out_valid), 0);
    check("t1.events",     ev_cnt - base, 1);

    for (int i = 0; i < NV; i++) begin
      in_data   = vt[i].din;
      in_valid  = vt[i].vld;
      out_ready = vt[i].rdy;
      clr_count = vt[i].clr;
      base = ev_cnt;
      repeat (vt[i].ncyc) @(negedge clk);
      check($sformatf("v%0d.link_up", i),   int'(link_up), int'(vt[i].link));
      check($sformatf("v%0d.send_rf", i),   int'(tx_send_rf), int'(vt[i].rf));
      check($sformatf("v%0d.send_idle", i), int'(tx_send_idle), int'(vt[i].idle));
      check($sformatf("v%0d.out_valid", i), int'(out_valid), int'(vt[i].ov));
      if (vt[i].ov) check($sformatf("v%0d.out_data", i), int'(out_data), int'(vt[i].od));
      check($sformatf("v%0d.overflow", i),  int'(evt_overflow), int'(vt[i].ovf));
      check($sformatf("v%0d.count", i),     int'(fault_count), vt[i].cnt);
      check($sformatf("v%0d.events", i),    ev_cnt - base, vt[i].nev);
    end
    clr_count = 1'b0;

    // Reset mid-HOLD, mid-cycle: outputs must drop back before the next edge.
    #2 reset = 1'b1;
    #1;
    check("mrst.link_up",   int'(link_up), 0);
    check("mrst.send_idle", int'(tx_send_idle), 1);
    check("mrst.send_rf",   int'(tx_send_rf), 0);
    check("mrst.out_valid", int'(out_valid), 0);
    check("mrst.out_data",  int'(out_data), 3);
    check("mrst.count",     int'(fault_count), 0);
    repeat (2) @(negedge clk);
    check("mrst.hold_out_valid", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
